// File: rtl/decoder_scan_ctrl.sv
// Decoder scan controller: steps a 2-bit decoder select through 0..3,
// holding each select for dwell+1 clock cycles. It runs either
// continuously or as a single pass.
//
// state | meaning
// IDLE  | decoder disabled, waiting for start
// RUN   | decoder enabled, counting slot cycles and stepping A
module decoder_scan_ctrl #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [DWELL_W-1:0] dwell,
    output logic [1:0]         A,
    output logic               E,
    output logic               busy,
    output logic               slot_tick,
    output logic               done
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] dwell_q;
    logic               mode_q;

    // Status flags are decoded from registers only, so there is no path from any input.
    assign busy      = (state == ST_RUN);
    assign slot_tick = (state == ST_RUN) && (cnt == dwell_q);

    // Scan sequencing: slot counter, decoder select/enable and the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            dwell_q <= '0;
            mode_q  <= 1'b0;
            A       <= 2'd0;
            E       <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    A   <= 2'd0;
                    E   <= 1'b0;
                    // stop overrides a simultaneous start
                    if (start && !stop) begin
                        state   <= ST_RUN;
                        dwell_q <= dwell;
                        mode_q  <= mode;
                        E       <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        A     <= 2'd0;
                        E     <= 1'b0;
                    end else if (cnt == dwell_q) begin
                        cnt <= '0;
                        if (mode_q && (A == 2'd3)) begin
                            state <= ST_IDLE;
                            A     <= 2'd0;
                            E     <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            A <= A + 2'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                    A     <= 2'd0;
                    E     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Directed bench for decoder_scan_ctrl: a vector table for the basic
// single-pass, continuous, stop and start/stop-collision behaviour, plus
// hand-written sequences for dwell changes, async reset and long slots.
module tb_decoder_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       mode;
    logic [7:0] dwell;
    logic [1:0] A;
    logic       E;
    logic       busy;
    logic       slot_tick;
    logic       done;

    int checks;
    int failures;

    typedef struct {
        logic       st;
        logic       sp;
        logic       md;
        logic [7:0] dw;
        logic [1:0] a;
        logic       e;
        logic       b;
        logic       t;
        logic       d;
    } vec_t;

    vec_t vecs[$];

    decoder_scan_ctrl #(.DWELL_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .dwell     (dwell),
        .A         (A),
        .E         (E),
        .busy      (busy),
        .slot_tick (slot_tick),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Packed output word {A, E, busy, slot_tick, done}.
    function automatic logic [5:0] outs();
        return {A, E, busy, slot_tick, done};
    endfunction

    task automatic add(input logic st, input logic sp, input logic md, input logic [7:0] dw,
                       input logic [1:0] a, input logic e, input logic b, input logic t, input logic d);
        vec_t v;
        v.st = st; v.sp = sp; v.md = md; v.dw = dw;
        v.a = a; v.e = e; v.b = b; v.t = t; v.d = d;
        vecs.push_back(v);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        start    = 1'b0;
        stop     = 1'b0;
        mode     = 1'b0;
        dwell    = 8'd0;
        rst_n    = 1'b0;

        // start+stop collision in IDLE
        add(1, 1, 1, 8'd2, 2'd0, 0, 0, 0, 0);
        // single pass, dwell=2; mode/dwell wiggled afterwards, start re-asserted mid-run
        add(1, 0, 1, 8'd2, 2'd0, 1, 1, 0, 0);
        add(0, 0, 0, 8'd5, 2'd0, 1, 1, 0, 0);
        add(0, 0, 0, 8'd5, 2'd0, 1, 1, 1, 0);
        add(0, 0, 0, 8'd5, 2'd1, 1, 1, 0, 0);
        add(0, 0, 0, 8'd5, 2'd1, 1, 1, 0, 0);
        add(0, 0, 0, 8'd5, 2'd1, 1, 1, 1, 0);
        add(0, 0, 0, 8'd5, 2'd2, 1, 1, 0, 0);
        add(1, 0, 0, 8'd5, 2'd2, 1, 1, 0, 0);
        add(0, 0, 0, 8'd5, 2'd2, 1, 1, 1, 0);
        add(0, 0, 0, 8'd5, 2'd3, 1, 1, 0, 0);
        add(0, 0, 0, 8'd5, 2'd3, 1, 1, 0, 0);
        add(0, 0, 0, 8'd5, 2'd3, 1, 1, 1, 0);
        add(0, 0, 0, 8'd5, 2'd0, 0, 0, 0, 1);
        // start during the done cycle: continuous, dwell=0
        add(1, 0, 0, 8'd0, 2'd0, 1, 1, 1, 0);
        add(0, 0, 1, 8'd9, 2'd1, 1, 1, 1, 0);
        add(0, 0, 1, 8'd9, 2'd2, 1, 1, 1, 0);
        add(0, 0, 1, 8'd9, 2'd3, 1, 1, 1, 0);
        add(0, 0, 1, 8'd9, 2'd0, 1, 1, 1, 0);
        add(0, 0, 1, 8'd9, 2'd1, 1, 1, 1, 0);
        // stop during A=1
        add(0, 1, 1, 8'd9, 2'd0, 0, 0, 0, 0);
        add(0, 0, 1, 8'd9, 2'd0, 0, 0, 0, 0);

        #1;
        check("reset_async_outs", {26'd0, outs()}, 32'd0);
        #12;
        rst_n = 1'b1;
        tick();
        check("reset_idle_outs", {26'd0, outs()}, 32'd0);

        foreach (vecs[i]) begin
            start = vecs[i].st;
            stop  = vecs[i].sp;
            mode  = vecs[i].md;
            dwell = vecs[i].dw;
            tick();
            check($sformatf("vec%0d", i), {26'd0, outs()},
                  {26'd0, vecs[i].a, vecs[i].e, vecs[i].b, vecs[i].t, vecs[i].d});
        end
        start = 1'b0;
        stop  = 1'b0;

        // dwell changed 3 -> 7 mid-scan: slots stay 4 cycles
        start = 1'b1; mode = 1'b0; dwell = 8'd3;
        tick();
        start = 1'b0; dwell = 8'd7;
        for (int k = 0; k < 12; k++) begin
            check($sformatf("dwchg_tick%0d", k), {31'd0, slot_tick}, {31'd0, (k % 4) == 3});
            check($sformatf("dwchg_a%0d", k), {30'd0, A}, k / 4);
            tick();
        end
        check("dwchg_wrap_a", {30'd0, A}, 32'd3);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("dwchg_stop_outs", {26'd0, outs()}, 32'd0);

        // async reset between edges while A=2, single mode so a done would be visible
        start = 1'b1; mode = 1'b1; dwell = 8'd1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("rst_pre_a", {30'd0, A}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_outs", {26'd0, outs()}, 32'd0);
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("rst_after%0d", k), {26'd0, outs()}, 32'd0);
        end

        // dwell=255: 256-cycle slots, continuous wrap 3 -> 0
        start = 1'b1; mode = 1'b0; dwell = 8'd255;
        tick();
        start = 1'b0;
        for (int k = 0; k < 1025; k++) begin
            check($sformatf("long_a%0d", k), {30'd0, A}, (k / 256) % 4);
            check($sformatf("long_tick%0d", k), {31'd0, slot_tick}, {31'd0, (k % 256) == 255});
            check($sformatf("long_e%0d", k), {31'd0, E}, 32'd1);
            tick();
        end
        check("long_wrap_a", {30'd0, A}, 32'd0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("long_stop_outs", {26'd0, outs()}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decoder_scan_ctrl.md
DECODER_SCAN_CTRL -- requirements
Module: decoder_scan_ctrl

Interface
REQ-001 SHALL have parameter DWELL_W, default 8: width of the dwell input and the internal slot counter.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: begins a scan when sampled high in IDLE.
REQ-005 SHALL have port stop, input, 1 bit: aborts a scan when sampled high in RUN.
REQ-006 SHALL have port mode, input, 1 bit: 0 selects continuous scan, 1 selects a single pass; sampled with start.
REQ-007 SHALL have port dwell, input, DWELL_W bits: slot length minus one, in clk cycles; sampled with start.
REQ-008 SHALL have port A, output, 2 bits: decoder select, registered.
REQ-009 SHALL have port E, output, 1 bit: decoder enable, registered.
REQ-010 SHALL have port busy, output, 1 bit: high while in RUN.
REQ-011 SHALL have port slot_tick, output, 1 bit: one-cycle pulse marking the last cycle of each slot.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse when a single pass completes.

Function
REQ-013 SHALL implement a two-state FSM, IDLE and RUN; the encoding is free.
REQ-014 IDLE outputs SHALL be E=0, A=0, busy=0 and slot_tick=0.
REQ-015 IDLE with start=1 and stop=0 SHALL, on the next edge, enter RUN, clear the counter to 0, set A=0 and E=1, and latch mode and dwell.
REQ-016 RUN outputs SHALL be E=1 and busy=1; the counter SHALL increment by 1 each cycle.
REQ-017 Each slot SHALL last exactly latched dwell+1 cycles; dwell=0 SHALL give one-cycle slots.
REQ-018 slot_tick SHALL be 1 exactly during the RUN cycles in which the counter equals the latched dwell.
REQ-019 On the edge following a slot_tick cycle, the counter SHALL clear to 0 and A SHALL advance by 1 modulo 4 (3 -> 0 wrap).
REQ-020 In continuous mode, the scan SHALL repeat 0,1,2,3,0,... until stop is asserted.
REQ-021 In single mode, on the edge following the slot_tick cycle with A=3, the FSM SHALL enter IDLE with E=0 and A=0.
REQ-022 In single mode, done SHALL be 1 for exactly the first IDLE cycle after that transition.
REQ-023 done SHALL be 0 at all other times, including after a stop.
REQ-024 stop=1 in RUN SHALL force IDLE on the next edge (E=0, A=0, counter=0) with no done pulse, regardless of counter or slot.
REQ-025 When start and stop are both 1, stop SHALL win; in IDLE the FSM SHALL stay in IDLE.
REQ-026 start in RUN SHALL be ignored; changes to dwell or mode during RUN SHALL have no effect until the next start.
REQ-027 start=1 in the IDLE cycle where done=1 SHALL start a new scan normally.
REQ-028 E and A SHALL change only together on clock edges, with no combinational path from inputs to A or E.

Reset
REQ-029 rst_n=0 SHALL immediately, without waiting for clk, force IDLE with A=0, E=0, busy=0, slot_tick=0, done=0, counter=0 and latched mode and dwell cleared.
REQ-030 Reset asserted mid-scan SHALL abort the scan with no done pulse; after release the block SHALL wait in IDLE for start.

Verification
REQ-031 Bench SHALL cover: start with mode=1, dwell=2 -> A=0,1,2,3 for 3 cycles each with E=1; slot_tick on the 3rd cycle of each slot; then E=0, A=0 and done=1 for one cycle.
REQ-032 Bench SHALL cover: start with mode=0, dwell=0 -> A cycles 0,1,2,3,0,1 on successive cycles with slot_tick=1 every cycle; stop during A=1 -> next cycle E=0, A=0, done=0.
REQ-033 Bench SHALL cover: start and stop both 1 in IDLE -> remains IDLE with E=0 and busy=0.
REQ-034 Bench SHALL cover: dwell changed from 3 to 7 mid-scan -> slots stay 4 cycles long until a restart.
REQ-035 Bench SHALL cover: rst_n pulsed low between clock edges while A=2 -> A=0, E=0 and busy=0 immediately, and no done pulse afterwards.
REQ-036 Bench SHALL cover: dwell=255 with DWELL_W=8 -> 256-cycle slots with no counter overflow, then A wraps 3 -> 0 in continuous mode.
